mult_div_unit: RTL

Multiply/divide unit for the five-stage pipeline. It sits beside the execute stage and owns the HI/LO registers. It runs MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency, and it drives `busy` to the hazard unit, which stalls any HI/LO-related instruction in D while the unit is occupied. MTHI/MTLO write HI/LO directly, and the execute stage reads `hi`/`lo` combinationally for MFHI/MFLO.

---
 rtl/mult_div_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO owner for the pipeline. Runs MULT/MULTU/DIV/DIVU with a
// fixed busy latency and handles MTHI/MTLO as single-edge writes.
// Optional build macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (md_op 7-10).
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         op_q;
    logic [31:0]        op_a;
    logic [31:0]        op_b;

    logic               launch_mul;
    logic               launch_div;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic               dvd_neg;
    logic               dvs_neg;
    logic [31:0]        dvd_mag;
    logic [31:0]        dvs_mag;
    logic [31:0]        quo_mag;
    logic [31:0]        rem_mag;
    logic [31:0]        quo;
    logic [31:0]        rem;

    logic               res_wr;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;

    // Classify the incoming opcode into multiply-latency and divide-latency launches
    always_comb begin
        launch_mul = 1'b0;
        launch_div = 1'b0;
        case (md_op)
            OP_MULT, OP_MULTU: launch_mul = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: launch_mul = 1'b1;
`endif
            OP_DIV, OP_DIVU:   launch_div = 1'b1;
            default: begin
                launch_mul = 1'b0;
                launch_div = 1'b0;
            end
        endcase
    end

    // Datapath on the latched operands: products and a shared magnitude divider
    always_comb begin
        prod_s  = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
        prod_u  = {32'd0, op_a} * {32'd0, op_b};
        dvd_neg = (op_q == OP_DIV) && op_a[31];
        dvs_neg = (op_q == OP_DIV) && op_b[31];
        dvd_mag = dvd_neg ? 32'(-op_a) : op_a;
        dvs_mag = dvs_neg ? 32'(-op_b) : op_b;
        // Guard the zero divisor so the divider never produces X in simulation
        quo_mag = (dvs_mag == 32'd0) ? 32'd0 : dvd_mag / dvs_mag;
        rem_mag = (dvs_mag == 32'd0) ? 32'd0 : dvd_mag % dvs_mag;
        // Quotient truncates toward zero; remainder follows the dividend's sign
        quo     = (dvd_neg ^ dvs_neg) ? 32'(-quo_mag) : quo_mag;
        rem     = dvd_neg ? 32'(-rem_mag) : rem_mag;
    end

    // Select the value committed to HI/LO when the run completes
    always_comb begin
        res_wr = 1'b1;
        res_hi = hi;
        res_lo = lo;
        case (op_q)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                // Divide by zero burns the full latency but leaves HI/LO alone
                res_wr = (op_b != 32'd0);
                res_hi = rem;
                res_lo = quo;
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
            OP_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
            OP_MSUB:  {res_hi, res_lo} = {hi, lo} - prod_s;
            OP_MSUBU: {res_hi, res_lo} = {hi, lo} - prod_u;
`endif
            default:  res_wr = 1'b0;
        endcase
    end

    // Control FSM, cycle counter, operand latches and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            op_q  <= OP_NONE;
            op_a  <= 32'd0;
            op_b  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (launch_mul || launch_div) begin
                            op_q  <= md_op;
                            op_a  <= a;
                            op_b  <= b;
                            cnt   <= launch_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            busy  <= 1'b1;
                            state <= RUN;
                        end else if (md_op == OP_MTHI) begin
                            hi <= a;
                        end else if (md_op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (res_wr) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
